// File: rtl/snake_pixel_store.sv
// Snake game state: circular position queue plus occupancy bitmap, move/grow update FSM,
// and a registered per-pixel colour lookup that feeds a WS2812 serialiser.
module snake_pixel_store #(
  parameter int          GRID_W     = 8,
  parameter int          GRID_H     = 8,
  parameter int          IDX_W      = 6,
  parameter int          MAX_LEN    = 16,
  parameter int          LEN_W      = 5,
  parameter logic [23:0] HEAD_COLOR = 24'h001100,
  parameter logic [23:0] BODY_COLOR = 24'h110000,
  parameter logic [23:0] FOOD_COLOR = 24'h000011,
  parameter logic [23:0] DEAD_COLOR = 24'h111100,
  parameter logic [23:0] BG_COLOR   = 24'h000000
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             start,
  input  logic [IDX_W-1:0] start_idx,
  input  logic [IDX_W-1:0] food_idx,
  input  logic             move_vld,
  output logic             move_rdy,
  input  logic [IDX_W-1:0] move_idx,
  input  logic             move_grow,
  input  logic             pix_req,
  input  logic [IDX_W-1:0] pix_idx,
  input  logic [4:0]       cnt_bit,
  output logic             pix_vld,
  output logic [23:0]      pix_color,
  output logic             bit_out,
  output logic [LEN_W-1:0] snake_len,
  output logic             eat,
  output logic             collide,
  output logic             game_over
);

  localparam int NPIX    = GRID_W * GRID_H;
  localparam int BM_SIZE = 1 << IDX_W;
  localparam int PTR_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [IDX_W:0]   NPIX_LIM = (IDX_W+1)'(NPIX);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_LEN - 1);

  typedef enum logic [1:0] {IDLE, RUN, UPD, OVER} state_t;

  state_t           state_reg, state_next;
  logic [BM_SIZE-1:0] bitmap_reg;
  logic [IDX_W-1:0] queue_reg [MAX_LEN];
  logic [PTR_W-1:0] head_ptr_reg, tail_ptr_reg;
  logic [LEN_W-1:0] len_reg;
  logic [IDX_W-1:0] mv_idx_reg;
  logic             mv_grow_reg;
  logic             eat_reg, collide_reg, pix_vld_reg;
  logic [23:0]      pix_color_reg;

  logic             start_ok, accept, grow_eff, vacate, hit;
  logic [IDX_W-1:0] head_pos, tail_pos;
  logic [PTR_W-1:0] head_ptr_inc, tail_ptr_inc;
  logic [23:0]      lookup_color;

  function automatic logic in_grid(input logic [IDX_W-1:0] idx);
    return {1'b0, idx} < NPIX_LIM;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign start_ok     = start && in_grid(start_idx);
  assign accept       = move_vld && (state_reg == RUN) && !start_ok;
  assign head_pos     = queue_reg[head_ptr_reg];
  assign tail_pos     = queue_reg[tail_ptr_reg];
  assign head_ptr_inc = ptr_inc(head_ptr_reg);
  assign tail_ptr_inc = ptr_inc(tail_ptr_reg);
  assign grow_eff     = mv_grow_reg && (len_reg < LEN_MAX);
  assign vacate       = !grow_eff;
  // Moving onto the tail cell is legal when that tail is leaving on this same move.
  assign hit = !in_grid(mv_idx_reg) ||
               (bitmap_reg[mv_idx_reg] && !(vacate && (mv_idx_reg == tail_pos)));

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    move_rdy   = 1'b0;
    game_over  = 1'b0;
    case (state_reg)
      RUN: begin
        move_rdy = 1'b1;
        if (move_vld) state_next = UPD;
      end
      UPD:     state_next = hit ? OVER : RUN;
      OVER:    game_over  = 1'b1;
      default: state_next = state_reg;
    endcase
    if (start_ok) state_next = RUN;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      bitmap_reg   <= '0;
      head_ptr_reg <= '0;
      tail_ptr_reg <= '0;
      len_reg      <= '0;
      mv_idx_reg   <= '0;
      mv_grow_reg  <= 1'b0;
      eat_reg      <= 1'b0;
      collide_reg  <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) queue_reg[i] <= '0;
    end else begin
      eat_reg     <= 1'b0;
      collide_reg <= 1'b0;
      if (start_ok) begin
        bitmap_reg            <= '0;
        bitmap_reg[start_idx] <= 1'b1;
        queue_reg[0]          <= start_idx;
        head_ptr_reg          <= '0;
        tail_ptr_reg          <= '0;
        len_reg               <= LEN_W'(1);
      end else if (accept) begin
        mv_idx_reg  <= move_idx;
        mv_grow_reg <= move_grow;
      end else if (state_reg == UPD) begin
        if (hit) begin
          collide_reg <= 1'b1;
        end else begin
          // Tail clear first so the set below wins when the head takes the tail cell.
          if (vacate) begin
            bitmap_reg[tail_pos] <= 1'b0;
            tail_ptr_reg         <= tail_ptr_inc;
          end
          bitmap_reg[mv_idx_reg]  <= 1'b1;
          queue_reg[head_ptr_inc] <= mv_idx_reg;
          head_ptr_reg            <= head_ptr_inc;
          len_reg                 <= len_reg + LEN_W'(grow_eff);
          eat_reg                 <= (mv_idx_reg == food_idx);
        end
      end
    end
  end

  always_comb begin
    lookup_color = BG_COLOR;
    if (in_grid(pix_idx)) begin
      if ((state_reg != IDLE) && (pix_idx == head_pos))
        lookup_color = (state_reg == OVER) ? DEAD_COLOR : HEAD_COLOR;
      else if (bitmap_reg[pix_idx])
        lookup_color = (state_reg == OVER) ? DEAD_COLOR : BODY_COLOR;
      else if (pix_idx == food_idx)
        lookup_color = FOOD_COLOR;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      pix_vld_reg   <= 1'b0;
      pix_color_reg <= '0;
    end else begin
      pix_vld_reg <= pix_req;
      if (pix_req) pix_color_reg <= lookup_color;
    end
  end

  assign pix_vld   = pix_vld_reg;
  assign pix_color = pix_color_reg;
  assign bit_out   = (cnt_bit <= 5'd23) ? pix_color_reg[5'd23 - cnt_bit] : 1'b0;
  assign snake_len = len_reg;
  assign eat       = eat_reg;
  assign collide   = collide_reg;

endmodule

// File: tb/tb_snake_pixel_store.sv
// Directed bench for snake_pixel_store: move vector table plus hand-written corner sequences.
// The DUT uses a 7-bit index so out-of-grid positions (64, 100) can be driven.
module tb_snake_pixel_store;

  localparam int IDX_W = 7;
  localparam int LEN_W = 5;

  logic             clk = 1'b0;
  logic             srst;
  logic             start;
  logic [IDX_W-1:0] start_idx, food_idx, move_idx, pix_idx;
  logic             move_vld, move_rdy, move_grow, pix_req, pix_vld, bit_out;
  logic [4:0]       cnt_bit;
  logic [23:0]      pix_color;
  logic [LEN_W-1:0] snake_len;
  logic             eat, collide, game_over;

  int checks = 0;
  int errors = 0;

  snake_pixel_store #(.IDX_W(IDX_W)) dut (
    .sys_clk(clk), .sys_rst(srst), .start(start), .start_idx(start_idx),
    .food_idx(food_idx), .move_vld(move_vld), .move_rdy(move_rdy),
    .move_idx(move_idx), .move_grow(move_grow), .pix_req(pix_req),
    .pix_idx(pix_idx), .cnt_bit(cnt_bit), .pix_vld(pix_vld),
    .pix_color(pix_color), .bit_out(bit_out), .snake_len(snake_len),
    .eat(eat), .collide(collide), .game_over(game_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IDX_W-1:0] idx;
    logic             grow;
    logic [IDX_W-1:0] food;
    logic             exp_eat;
    logic             exp_col;
    int               exp_len;
    logic             exp_over;
  } mv_vec_t;

  typedef struct {
    logic [IDX_W-1:0] idx;
    logic [4:0]       cb;
    logic [23:0]      color;
    logic             bitv;
  } lk_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [IDX_W-1:0] idx);
    start_idx = idx;
    start = 1'b1;
    tick();
    start = 1'b0;
    $display("start idx=%0d len=%0d rdy=%0d", idx, snake_len, move_rdy);
  endtask

  task automatic do_move(input logic [IDX_W-1:0] idx, input logic grow, input logic [IDX_W-1:0] food);
    food_idx  = food;
    move_idx  = idx;
    move_grow = grow;
    check("move_rdy_before", 32'(move_rdy), 32'd1);
    move_vld = 1'b1;
    tick();
    move_vld = 1'b0;
    tick();
    $display("move idx=%0d grow=%0d eat=%0d collide=%0d len=%0d over=%0d",
             idx, grow, eat, collide, snake_len, game_over);
  endtask

  task automatic lookup(input logic [IDX_W-1:0] idx, input logic [4:0] cb,
                        input logic [23:0] exp_color, input logic exp_bit);
    pix_idx = idx;
    cnt_bit = cb;
    pix_req = 1'b1;
    tick();
    pix_req = 1'b0;
    $display("lookup idx=%0d cnt_bit=%0d color=%06h bit=%0d", idx, cb, pix_color, bit_out);
    check("pix_vld", 32'(pix_vld), 32'd1);
    check($sformatf("pix_color_%0d", idx), 32'(pix_color), 32'(exp_color));
    check($sformatf("bit_out_%0d_%0d", idx, cb), 32'(bit_out), 32'(exp_bit));
  endtask

  mv_vec_t mv_tab[3];
  lk_vec_t lk_tab[5];

  initial begin
    mv_tab[0] = '{idx: 28, grow: 1, food: 29, exp_eat: 0, exp_col: 0, exp_len: 2, exp_over: 0};
    mv_tab[1] = '{idx: 29, grow: 1, food: 29, exp_eat: 1, exp_col: 0, exp_len: 3, exp_over: 0};
    mv_tab[2] = '{idx: 30, grow: 0, food: 29, exp_eat: 0, exp_col: 0, exp_len: 3, exp_over: 0};
    lk_tab[0] = '{idx: 27, cb: 0,  color: 24'h000000, bitv: 0};
    lk_tab[1] = '{idx: 28, cb: 7,  color: 24'h110000, bitv: 1};
    lk_tab[2] = '{idx: 29, cb: 3,  color: 24'h110000, bitv: 1};
    lk_tab[3] = '{idx: 30, cb: 11, color: 24'h001100, bitv: 1};
    lk_tab[4] = '{idx: 70, cb: 0,  color: 24'h000000, bitv: 0};

    srst = 1'b1; start = 1'b0; start_idx = '0; food_idx = 7'd29;
    move_vld = 1'b0; move_idx = '0; move_grow = 1'b0;
    pix_req = 1'b0; pix_idx = '0; cnt_bit = '0;
    tick(); tick();
    srst = 1'b0;

    // Reset state
    check("rst_move_rdy", 32'(move_rdy), 32'd0);
    check("rst_len", 32'(snake_len), 32'd0);
    check("rst_over", 32'(game_over), 32'd0);
    check("rst_pix_vld", 32'(pix_vld), 32'd0);
    check("rst_pix_color", 32'(pix_color), 32'd0);
    check("rst_eat_col", 32'({eat, collide}), 32'd0);

    // Out-of-grid start is ignored
    do_start(7'd100);
    check("bad_start_rdy", 32'(move_rdy), 32'd0);
    check("bad_start_len", 32'(snake_len), 32'd0);

    do_start(7'd27);
    check("start_len", 32'(snake_len), 32'd1);
    check("start_rdy", 32'(move_rdy), 32'd1);
    lookup(7'd27, 5'd11, 24'h001100, 1'b1);
    lookup(7'd28, 5'd0, 24'h000000, 1'b0);
    lookup(7'd27, 5'd24, 24'h001100, 1'b0);
    lookup(7'd29, 5'd23, 24'h000011, 1'b1);
    tick();
    check("pix_vld_idle", 32'(pix_vld), 32'd0);
    check("pix_color_hold", 32'(pix_color), 32'h000011);

    for (int i = 0; i < 3; i++) begin
      do_move(mv_tab[i].idx, mv_tab[i].grow, mv_tab[i].food);
      check($sformatf("tab%0d_eat", i), 32'(eat), 32'(mv_tab[i].exp_eat));
      check($sformatf("tab%0d_collide", i), 32'(collide), 32'(mv_tab[i].exp_col));
      check($sformatf("tab%0d_len", i), 32'(snake_len), 32'(mv_tab[i].exp_len));
      check($sformatf("tab%0d_over", i), 32'(game_over), 32'(mv_tab[i].exp_over));
    end
    tick();
    check("eat_one_cycle", 32'(eat), 32'd0);
    for (int i = 0; i < 5; i++) lookup(lk_tab[i].idx, lk_tab[i].cb, lk_tab[i].color, lk_tab[i].bitv);

    // Length saturation
    do_start(7'd0);
    for (int i = 1; i <= 15; i++) begin
      do_move(7'(i), 1'b1, 7'd63);
      check($sformatf("sat_len_%0d", i), 32'(snake_len), 32'(i + 1));
    end
    do_move(7'd16, 1'b1, 7'd63);
    check("sat_len_full", 32'(snake_len), 32'd16);
    check("sat_collide", 32'(collide), 32'd0);
    lookup(7'd0, 5'd0, 24'h000000, 1'b0);
    lookup(7'd1, 5'd7, 24'h110000, 1'b1);
    lookup(7'd16, 5'd11, 24'h001100, 1'b1);

    // Square loop: chase the vacating tail, then the same with grow
    do_start(7'd0);
    do_move(7'd1, 1'b1, 7'd63);
    do_move(7'd9, 1'b1, 7'd63);
    do_move(7'd8, 1'b1, 7'd63);
    check("loop_len", 32'(snake_len), 32'd4);
    do_move(7'd0, 1'b0, 7'd63);
    check("loop_tail_collide", 32'(collide), 32'd0);
    check("loop_tail_len", 32'(snake_len), 32'd4);
    do_move(7'd1, 1'b1, 7'd63);
    check("loop_grow_collide", 32'(collide), 32'd1);
    check("loop_grow_over", 32'(game_over), 32'd1);
    check("loop_grow_rdy", 32'(move_rdy), 32'd0);
    check("loop_grow_len", 32'(snake_len), 32'd4);
    lookup(7'd9, 5'd3, 24'h111100, 1'b1);
    lookup(7'd0, 5'd0, 24'h111100, 1'b0);
    lookup(7'd63, 5'd23, 24'h000011, 1'b1);
    tick();
    check("collide_one_cycle", 32'(collide), 32'd0);
    check("over_sticky", 32'(game_over), 32'd1);
    do_start(7'd100);
    check("over_bad_start", 32'(game_over), 32'd1);

    // Out-of-grid move
    do_start(7'd10);
    check("restart_over", 32'(game_over), 32'd0);
    do_move(7'd64, 1'b0, 7'd63);
    check("oob_collide", 32'(collide), 32'd1);
    check("oob_over", 32'(game_over), 32'd1);

    // start together with move_vld in RUN
    do_start(7'd20);
    food_idx = 7'd21;
    start_idx = 7'd30; start = 1'b1;
    move_idx = 7'd21; move_grow = 1'b1; move_vld = 1'b1;
    tick();
    start = 1'b0; move_vld = 1'b0;
    check("startmv_len", 32'(snake_len), 32'd1);
    check("startmv_rdy", 32'(move_rdy), 32'd1);
    tick();
    check("startmv_eat_col", 32'({eat, collide}), 32'd0);
    check("startmv_len2", 32'(snake_len), 32'd1);
    lookup(7'd30, 5'd11, 24'h001100, 1'b1);
    lookup(7'd20, 5'd0, 24'h000000, 1'b0);

    // Reset while the move is in UPD
    food_idx = 7'd63;
    do_start(7'd5);
    move_idx = 7'd6; move_grow = 1'b1; move_vld = 1'b1;
    tick();
    move_vld = 1'b0; srst = 1'b1;
    tick();
    srst = 1'b0;
    check("updrst_len", 32'(snake_len), 32'd0);
    check("updrst_rdy", 32'(move_rdy), 32'd0);
    check("updrst_flags", 32'({eat, collide, game_over}), 32'd0);
    check("updrst_pix", 32'(pix_color), 32'd0);
    lookup(7'd5, 5'd0, 24'h000000, 1'b0);
    lookup(7'd6, 5'd0, 24'h000000, 1'b0);
    lookup(7'd63, 5'd23, 24'h000011, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
